// File: rtl/pll_lock_supervisor_pkg.sv
// pll_sup_pkg: state encoding, widths and constants shared by the PLL lock
// supervisor, its interface and its bench.
//   pll_state_e  : supervisor FSM states (the encoding is visible on state_o)
//   STATE_W      : width of the state_o status field
//   LOSS_CNT_MAX : saturation value of the lock-loss counter
//   max3()       : used to size the shared pulse/stable/timeout counters
package pll_sup_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam logic [15:0] LOSS_CNT_MAX = 16'hFFFF;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: signals between the lock supervisor and the PLL /
// downstream system.
//   locked_in     : PLL lock indication, asynchronous to refclk
//   soft_rst_req  : one-cycle request to restart the bring-up sequence
//   pll_rst       : PLL reset, active-high
//   sys_rst       : downstream reset, active-high
//   ready / fault : high in RUN / FAULT respectively
//   state_o       : current FSM state
//   retry_cnt     : lock timeouts in the current sequence
//   lock_loss_cnt : lock losses seen in RUN (saturating)
// master = supervisor side, slave = PLL/system side.
interface pll_lock_supervisor_if #(
  parameter int RETRY_W = 2
);
  import pll_sup_pkg::*;

  logic               locked_in;
  logic               soft_rst_req;
  logic               pll_rst;
  logic               sys_rst;
  logic               ready;
  logic               fault;
  logic [STATE_W-1:0] state_o;
  logic [RETRY_W-1:0] retry_cnt;
  logic [15:0]        lock_loss_cnt;

  modport master (
    input  locked_in, soft_rst_req,
    output pll_rst, sys_rst, ready, fault, state_o, retry_cnt, lock_loss_cnt
  );

  modport slave (
    output locked_in, soft_rst_req,
    input  pll_rst, sys_rst, ready, fault, state_o, retry_cnt, lock_loss_cnt
  );

endinterface

// File: rtl/pll_lock_supervisor_sync.sv
// pll_lock_sync: STAGES-deep flop chain bringing the asynchronous PLL lock
// indication into the refclk domain.
//   clk : refclk
//   rst : synchronous reset, active-high, clears the chain to 0
//   d   : asynchronous input
//   q   : synchronised output (last stage)
module pll_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_r <= '0;
    end else begin
      chain_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain_r[i] <= chain_r[i-1];
      end
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: pulses the PLL reset, waits for a stable lock, then
// releases sys_rst. Retries after lock timeouts, counts lock losses in RUN and
// parks in FAULT once the retries are used up.
//   refclk : the only clock
//   rst    : synchronous reset, active-high
//   bus    : master side of pll_lock_supervisor_if (lock input, soft restart
//            request, PLL/system resets and status outputs)
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input logic                   refclk,
  input logic                   rst,
  pll_lock_supervisor_if.master bus
);

  localparam int CNT_W   = $clog2(max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                       LOCK_TIMEOUT_CYCLES) + 1);
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  pll_state_e         state_r, state_nx_s;
  logic [CNT_W-1:0]   pulse_cnt_r, stable_cnt_r, timeout_cnt_r;
  logic [CNT_W-1:0]   pulse_nx_s, stable_nx_s, timeout_nx_s;
  logic [CNT_W-1:0]   pulse_inc_s, stable_inc_s, timeout_inc_s;
  logic [RETRY_W-1:0] retry_r, retry_nx_s;
  logic [15:0]        loss_cnt_r, loss_nx_s;
  logic               pll_rst_r, sys_rst_r, ready_r, fault_r;
  logic               locked_sync_s;
  logic               timeout_hit_s, stable_done_s, retry_left_s, clear_s;

  pll_lock_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.locked_in),
    .q   (locked_sync_s)
  );

  assign pulse_inc_s   = pulse_cnt_r + CNT_W'(1);
  assign stable_inc_s  = stable_cnt_r + CNT_W'(1);
  assign timeout_inc_s = timeout_cnt_r + CNT_W'(1);
  assign timeout_hit_s = (timeout_inc_s == CNT_W'(LOCK_TIMEOUT_CYCLES));
  // Stable-complete outranks a timeout landing on the same edge.
  assign stable_done_s = locked_sync_s && (stable_inc_s == CNT_W'(LOCK_STABLE_CYCLES));
  assign retry_left_s  = (retry_r < RETRY_W'(MAX_RETRIES));

  // Next state and next counter values; soft_rst_req overrides everything.
  always_comb begin
    state_nx_s   = state_r;
    pulse_nx_s   = pulse_cnt_r;
    stable_nx_s  = stable_cnt_r;
    timeout_nx_s = timeout_cnt_r;
    retry_nx_s   = retry_r;
    loss_nx_s    = loss_cnt_r;
    if (bus.soft_rst_req) begin
      state_nx_s = PLL_RST;
      retry_nx_s = '0;
    end else begin
      case (state_r)
        PLL_RST: begin
          if (pulse_inc_s == CNT_W'(PLL_RST_CYCLES)) begin
            state_nx_s = WAIT_LOCK;
          end else begin
            pulse_nx_s = pulse_inc_s;
          end
        end
        WAIT_LOCK: begin
          timeout_nx_s = timeout_inc_s;
          if (timeout_hit_s) begin
            state_nx_s = retry_left_s ? PLL_RST : FAULT;
            retry_nx_s = retry_left_s ? (retry_r + RETRY_W'(1)) : retry_r;
          end else if (locked_sync_s) begin
            state_nx_s = STABLE;
          end else begin
            state_nx_s = WAIT_LOCK;
          end
        end
        STABLE: begin
          timeout_nx_s = timeout_inc_s;
          if (stable_done_s) begin
            state_nx_s = RUN;
            retry_nx_s = '0;
          end else if (timeout_hit_s) begin
            state_nx_s = retry_left_s ? PLL_RST : FAULT;
            retry_nx_s = retry_left_s ? (retry_r + RETRY_W'(1)) : retry_r;
          end else if (locked_sync_s) begin
            stable_nx_s = stable_inc_s;
          end else begin
            // Lock glitch: the stable window has to start over.
            state_nx_s  = WAIT_LOCK;
            stable_nx_s = '0;
          end
        end
        RUN: begin
          if (locked_sync_s) begin
            state_nx_s = RUN;
          end else begin
            state_nx_s = PLL_RST;
            loss_nx_s  = (loss_cnt_r == LOSS_CNT_MAX) ? loss_cnt_r : (loss_cnt_r + 16'd1);
          end
        end
        FAULT: begin
          state_nx_s = FAULT;
        end
        default: begin
          state_nx_s = PLL_RST;
        end
      endcase
    end
  end

  // Any entry into PLL_RST (including a soft restart while already there)
  // starts a fresh pulse and a fresh lock attempt.
  assign clear_s = (state_nx_s == PLL_RST) && ((state_r != PLL_RST) || bus.soft_rst_req);

  // State, counters and outputs; outputs are decoded from the next state so
  // they are registered yet always agree with state_r.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_r       <= PLL_RST;
      pulse_cnt_r   <= '0;
      stable_cnt_r  <= '0;
      timeout_cnt_r <= '0;
      retry_r       <= '0;
      loss_cnt_r    <= 16'd0;
      pll_rst_r     <= 1'b1;
      sys_rst_r     <= 1'b1;
      ready_r       <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      pulse_cnt_r   <= clear_s ? '0 : pulse_nx_s;
      stable_cnt_r  <= clear_s ? '0 : stable_nx_s;
      timeout_cnt_r <= clear_s ? '0 : timeout_nx_s;
      retry_r       <= retry_nx_s;
      loss_cnt_r    <= loss_nx_s;
      pll_rst_r     <= (state_nx_s == PLL_RST) || (state_nx_s == FAULT);
      sys_rst_r     <= (state_nx_s != RUN);
      ready_r       <= (state_nx_s == RUN);
      fault_r       <= (state_nx_s == FAULT);
    end
  end

  assign bus.state_o       = state_r;
  assign bus.pll_rst       = pll_rst_r;
  assign bus.sys_rst       = sys_rst_r;
  assign bus.ready         = ready_r;
  assign bus.fault         = fault_r;
  assign bus.retry_cnt     = retry_r;
  assign bus.lock_loss_cnt = loss_cnt_r;

endmodule
